// File: rtl/exec_ctrl.sv
// Execute-phase control sequencer: requests a fetch, decodes the latched IR and
// steps the register-file, ALU and memory strobes through one instruction.
module exec_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        fetch_done,
  input  logic [15:0] IR,
  input  logic        MFC,
  output logic        fetch_start,
  output logic [3:0]  RF_addr_A,
  output logic [3:0]  RF_addr_B,
  output logic [3:0]  RF_wr_addr,
  output logic        RF_write,
  output logic        Y_write,
  output logic [2:0]  ALU_op,
  output logic        Z_write,
  output logic        Z_read,
  output logic        MAR_write,
  output logic        MDR_write,
  output logic        MDR_mem_write,
  output logic        MDR_read,
  output logic        MEM_EN,
  output logic        MEM_RW,
  output logic        halted,
  output logic        bus_error,
  output logic        illegal
);

  typedef enum logic [3:0] {
    StIdle, StFreq, StFwait, StDecode, StEx1, StEx2, StEx3, StMa,
    StSd, StMrd, StMwr, StMwait, StLdm, StLwb, StHalt
  } state_e;

  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] ir_q;
  logic [7:0]  wait_cnt_q;
  logic        bus_error_q;
  logic        mem_timeout;

  logic [3:0] op, rd, rs, rt;
  assign op = ir_q[15:12];
  assign rd = ir_q[11:8];
  assign rs = ir_q[7:4];
  assign rt = ir_q[3:0];

  // MFC on the final wait cycle still completes the access.
  assign mem_timeout = (state_q == StMwait) && !MFC && (wait_cnt_q == TimeoutLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q        <= '0;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      if (state_q == StFwait && fetch_done) begin
        ir_q <= IR;
      end
      if (state_q != StMwait) begin
        wait_cnt_q <= '0;
      end else if (!MFC) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
      if (mem_timeout) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  assign bus_error = bus_error_q;

  always_comb begin
    state_d       = state_q;
    fetch_start   = 1'b0;
    RF_addr_A     = 4'd0;
    RF_addr_B     = 4'd0;
    RF_wr_addr    = 4'd0;
    RF_write      = 1'b0;
    Y_write       = 1'b0;
    ALU_op        = 3'd0;
    Z_write       = 1'b0;
    Z_read        = 1'b0;
    MAR_write     = 1'b0;
    MDR_write     = 1'b0;
    MDR_mem_write = 1'b0;
    MDR_read      = 1'b0;
    MEM_EN        = 1'b0;
    MEM_RW        = 1'b0;
    halted        = 1'b0;
    illegal       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFreq;
      end
      StFreq: begin
        fetch_start = 1'b1;
        state_d     = StFwait;
      end
      StFwait: begin
        if (fetch_done) state_d = StDecode;
      end
      StDecode: begin
        if (op == 4'd0) begin
          state_d = StFreq;
        end else if (op <= 4'd4) begin
          state_d = StEx1;
        end else if (op == 4'd5 || op == 4'd6) begin
          state_d = StMa;
        end else if (op == 4'd7) begin
          state_d = StHalt;
        end else begin
          illegal = 1'b1;
          state_d = StFreq;
        end
      end
      StEx1: begin
        RF_addr_A = rs;
        Y_write   = 1'b1;
        state_d   = StEx2;
      end
      StEx2: begin
        RF_addr_B = rt;
        ALU_op    = 3'(op - 4'd1);
        Z_write   = 1'b1;
        state_d   = StEx3;
      end
      StEx3: begin
        Z_read     = 1'b1;
        RF_wr_addr = rd;
        RF_write   = 1'b1;
        state_d    = StFreq;
      end
      StMa: begin
        RF_addr_A = rs;
        MAR_write = 1'b1;
        state_d   = (op == 4'd6) ? StSd : StMrd;
      end
      StSd: begin
        RF_addr_B = rt;
        MDR_write = 1'b1;
        state_d   = StMwr;
      end
      StMrd: begin
        MEM_EN  = 1'b1;
        MEM_RW  = 1'b1;
        state_d = StMwait;
      end
      StMwr: begin
        MEM_EN  = 1'b1;
        state_d = StMwait;
      end
      StMwait: begin
        if (MFC) begin
          state_d = (op == 4'd6) ? StFreq : StLdm;
        end else if (mem_timeout) begin
          state_d = StHalt;
        end
      end
      StLdm: begin
        MDR_mem_write = 1'b1;
        state_d       = StLwb;
      end
      StLwb: begin
        MDR_read   = 1'b1;
        RF_wr_addr = rd;
        RF_write   = 1'b1;
        state_d    = StFreq;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule
